stack_nt: RTL and testbench

STACK_NT -- requirements
Module: stack_nt

---
 rtl/stack_nt.sv | 124 ++++++++++++
 tb/tb_stack_nt.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/stack_nt.sv
// LIFO stack with a tristate top-of-stack bus and sticky overflow/underflow flags.
// Latency: a push or replace is visible on data_out right after the same rising edge.
// Backpressure: none; a push while full overwrites the oldest entry (WRAP=1) or is dropped (WRAP=0).
//
// Ports:
//   clock, reset_n            - rising-edge clock, asynchronous active-low reset
//   push, pop                 - push data_in / discard top; both together replace the top
//   out_en                    - drives the top of stack onto data_out, otherwise data_out is Z
//   clear_flags               - clears overflow/underflow (a new event in the same cycle wins)
//   data_in, data_out         - write word / tristate top-of-stack bus (zeros when empty)
//   count, empty, full        - occupancy 0..DEPTH
//   overflow, underflow       - sticky error flags
module stack_nt #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter bit          WRAP  = 1'b1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         out_en,
    input  logic                         clear_flags,
    input  logic [WIDTH-1:0]             data_in,
    output wire  [WIDTH-1:0]             data_out,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned SPW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [SPW-1:0]   sp_q, sp_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic             wr_en;
    logic [SPW-1:0]   wr_addr;
    logic [SPW-1:0]   sp_m1;
    logic             is_empty, is_full;
    logic             ovf_evt, udf_evt;
    logic [WIDTH-1:0] top_dat;

    assign sp_m1    = sp_q - SPW'(1);
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));

    always_comb begin
        sp_d    = sp_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_addr = sp_q;
        ovf_evt = 1'b0;
        udf_evt = 1'b0;

        if (push && pop && !is_empty) begin
            // Replace the top in place; occupancy unchanged, never an error.
            wr_en   = 1'b1;
            wr_addr = sp_m1;
        end else if (push) begin
            // Also covers push+pop on an empty stack, which degenerates to a push.
            if (!is_full) begin
                wr_en   = 1'b1;
                sp_d    = sp_q + SPW'(1);
                count_d = count_q + CW'(1);
            end else begin
                ovf_evt = 1'b1;
                if (WRAP) begin
                    // sp already points at the oldest slot when full.
                    wr_en = 1'b1;
                    sp_d  = sp_q + SPW'(1);
                end
            end
        end else if (pop) begin
            if (!is_empty) begin
                sp_d    = sp_m1;
                count_d = count_q - CW'(1);
            end else begin
                udf_evt = 1'b1;
            end
        end

        // Set has priority over clear.
        ovf_d = ovf_evt | (ovf_q & ~clear_flags);
        udf_d = udf_evt | (udf_q & ~clear_flags);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is deliberately not reset; writes are suppressed while reset is held.
    always_ff @(posedge clock) begin
        if (wr_en && reset_n) begin
            mem_q[wr_addr] <= data_in;
        end
    end

    // An empty stack reads zeros so stale storage never leaks out after reset.
    assign top_dat  = is_empty ? '0 : mem_q[sp_m1];
    assign data_out = out_en ? top_dat : {WIDTH{1'bz}};

    assign count     = count_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: tb/tb_stack_nt.sv
module tb_stack_nt;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       push, pop, out_en, clear_flags;
    logic [7:0] data_in;

    wire  [7:0] data_out;
    logic [3:0] count;
    logic       empty, full, overflow, underflow;

    wire  [7:0] data_out0;
    logic [3:0] count0;
    logic       empty0, full0, overflow0, underflow0;

    int checks   = 0;
    int failures = 0;

    // Reference model: back of the queue is the top of the stack.
    logic [7:0] mdl[$];
    bit         m_ovf, m_udf;

    always #5 clock = ~clock;

    stack_nt #(.WIDTH(8), .DEPTH(8), .WRAP(1'b1)) u_dut (
        .clock(clock), .reset_n(reset_n), .push(push), .pop(pop),
        .out_en(out_en), .clear_flags(clear_flags), .data_in(data_in),
        .data_out(data_out), .count(count), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow)
    );

    stack_nt #(.WIDTH(8), .DEPTH(8), .WRAP(1'b0)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .push(push), .pop(pop),
        .out_en(out_en), .clear_flags(clear_flags), .data_in(data_in),
        .data_out(data_out0), .count(count0), .empty(empty0), .full(full0),
        .overflow(overflow0), .underflow(underflow0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // An undriven bus reads Z in four-state simulators and 0 in two-state ones;
    // either is acceptable, the driven top value is not.
    task automatic chk_z(input string tag);
        checks++;
        assert ((data_out === 8'hzz) || (data_out === 8'h00)) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=zz", tag, data_out);
        end
    endtask

    task automatic chk_state(input string tag);
        logic [7:0] exp_top;
        exp_top = (mdl.size() > 0) ? mdl[mdl.size()-1] : 8'h00;
        chk({tag, ".count"},     32'(count),     32'(mdl.size()));
        chk({tag, ".empty"},     32'(empty),     32'(mdl.size() == 0));
        chk({tag, ".full"},      32'(full),      32'(mdl.size() == 8));
        chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
        chk({tag, ".data_out"},  32'(data_out),  32'(exp_top));
    endtask

    // One clock of stimulus followed by model update and full state check.
    task automatic step(input string tag, input bit ps, input bit pp, input bit clr,
                        input logic [7:0] d);
        bit ov_e, ud_e;
        @(negedge clock);
        push = ps; pop = pp; clear_flags = clr; data_in = d;
        @(posedge clock);
        #1;
        push = 1'b0; pop = 1'b0; clear_flags = 1'b0;
        ov_e = 1'b0; ud_e = 1'b0;
        if (ps && pp && mdl.size() > 0) begin
            mdl[mdl.size()-1] = d;
        end else if (ps) begin
            if (mdl.size() < 8) begin
                mdl.push_back(d);
            end else begin
                ov_e = 1'b1;
                void'(mdl.pop_front());
                mdl.push_back(d);
            end
        end else if (pp) begin
            if (mdl.size() > 0) void'(mdl.pop_back());
            else ud_e = 1'b1;
        end
        m_ovf = ov_e | (m_ovf & !clr);
        m_udf = ud_e | (m_udf & !clr);
        chk_state(tag);
    endtask

    initial begin
        reset_n = 1'b0; push = 1'b0; pop = 1'b0; out_en = 1'b1;
        clear_flags = 1'b0; data_in = 8'h00;
        m_ovf = 1'b0; m_udf = 1'b0;
        #12;
        chk_state("reset");
        out_en = 1'b0; #1;
        chk_z("reset_z");
        out_en = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;

        // Fill 0x11..0x88.
        for (int i = 1; i <= 8; i++) step("fill", 1'b1, 1'b0, 1'b0, 8'(i * 8'h11));
        chk("wrap0.full.count", 32'(count0), 32'd8);

        // Overflow: WRAP=1 overwrites oldest, WRAP=0 drops the word.
        step("ovf_wrap1", 1'b1, 1'b0, 1'b0, 8'h99);
        chk("wrap0.overflow", 32'(overflow0), 32'd1);
        chk("wrap0.count",    32'(count0),    32'd8);
        chk("wrap0.top",      32'(data_out0), 32'h88);

        step("clear_ovf", 1'b0, 1'b0, 1'b1, 8'h00);
        // Replace top while full: no overflow.
        step("replace_full", 1'b1, 1'b1, 1'b0, 8'hC3);
        step("replace_back", 1'b1, 1'b1, 1'b0, 8'h99);

        // Drain: 0x99, 0x88..0x22, then empty reads zero.
        for (int i = 0; i < 8; i++) step("drain", 1'b0, 1'b1, 1'b0, 8'h00);

        // Underflow and empty-stack corner cases.
        step("pop_empty",     1'b0, 1'b1, 1'b0, 8'h00);
        step("pushpop_empty", 1'b1, 1'b1, 1'b0, 8'h5A);
        step("pop_to_empty",  1'b0, 1'b1, 1'b0, 8'h00);
        step("clr_and_udf",   1'b0, 1'b1, 1'b1, 8'h00);
        step("clr_udf",       1'b0, 1'b0, 1'b1, 8'h00);

        // Replace top on a partially filled stack, then the tristate bus.
        step("push01",  1'b1, 1'b0, 1'b0, 8'h01);
        step("push02",  1'b1, 1'b0, 1'b0, 8'h02);
        step("repl7f",  1'b1, 1'b1, 1'b0, 8'h7F);
        out_en = 1'b0; #1;
        chk_z("out_en0");
        out_en = 1'b1; #1;
        chk("out_en1", 32'(data_out), 32'h7F);
        step("push03",  1'b1, 1'b0, 1'b0, 8'h03);

        // Asynchronous reset between edges with count=3.
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        mdl.delete(); m_ovf = 1'b0; m_udf = 1'b0;
        chk_state("async_rst");

        // A push held through reset is aborted; the first edge after release acts.
        push = 1'b1; data_in = 8'hAA;
        @(posedge clock);
        #1;
        chk("rst_abort.count", 32'(count), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        push = 1'b0;
        mdl.push_back(8'hAA);
        chk_state("post_rst_push");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
